// File: rtl/hpdcache_axi_to_mem_write_if.sv
// Types and bus bundle for hpdcache_axi_to_mem_write.
// The package holds the default AXI and hpdcache memory-side structs. The
// interface groups every handshake/payload signal of the block. Signal names
// keep the block's original port names, so the suffixes (_i/_o) are as seen
// from the responder.
//   slave  modport : responder view (AXI AW/W in, B out; mem req/data out,
//                    mem write response in)
//   master modport : environment view (initiator + memory)
package hpdcache_axi_to_mem_write_pkg;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_READ   = 2'd0,
        HPDCACHE_MEM_WRITE  = 2'd1,
        HPDCACHE_MEM_ATOMIC = 2'd2
    } hpdcache_mem_command_e;

    typedef enum logic [3:0] {
        HPDCACHE_MEM_ATOMIC_ADD  = 4'd0,
        HPDCACHE_MEM_ATOMIC_CLR  = 4'd1,
        HPDCACHE_MEM_ATOMIC_SET  = 4'd2,
        HPDCACHE_MEM_ATOMIC_EOR  = 4'd3,
        HPDCACHE_MEM_ATOMIC_SMAX = 4'd4,
        HPDCACHE_MEM_ATOMIC_SMIN = 4'd5,
        HPDCACHE_MEM_ATOMIC_UMAX = 4'd6,
        HPDCACHE_MEM_ATOMIC_UMIN = 4'd7,
        HPDCACHE_MEM_ATOMIC_SWAP = 4'd8,
        HPDCACHE_MEM_ATOMIC_LDEX = 4'd10,
        HPDCACHE_MEM_ATOMIC_STEX = 4'd11
    } hpdcache_mem_atomic_e;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_RESP_OK  = 2'd0,
        HPDCACHE_MEM_RESP_NOK = 2'd1
    } hpdcache_mem_error_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] ATOP_NONE        = 2'b00;
    localparam logic [1:0] ATOP_ATOMICSTORE = 2'b01;
    localparam logic [1:0] ATOP_ATOMICLOAD  = 2'b10;
    localparam logic [1:0] ATOP_ATOMICSWCMP = 2'b11;

    typedef struct packed {
        logic [ADDR_W-1:0]    mem_req_addr;
        logic [7:0]           mem_req_len;
        logic [2:0]           mem_req_size;
        logic [ID_W-1:0]      mem_req_id;
        hpdcache_mem_command_e mem_req_command;
        hpdcache_mem_atomic_e mem_req_atomic;
        logic                 mem_req_cacheable;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] mem_req_w_data;
        logic [BE_W-1:0]   mem_req_w_be;
        logic              mem_req_w_last;
    } hpdcache_mem_req_w_t;

    typedef struct packed {
        hpdcache_mem_error_e mem_resp_w_error;
        logic [ID_W-1:0]     mem_resp_w_id;
        logic                mem_resp_w_is_atomic;
    } hpdcache_mem_resp_w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   strb;
        logic              last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_chan_t;
endpackage

interface hpdcache_axi_to_mem_write_if;
    import hpdcache_axi_to_mem_write_pkg::*;

    logic                 axi_aw_valid_i;
    aw_chan_t             axi_aw_i;
    logic                 axi_aw_ready_o;
    logic                 axi_w_valid_i;
    w_chan_t              axi_w_i;
    logic                 axi_w_ready_o;
    logic                 axi_b_valid_o;
    b_chan_t              axi_b_o;
    logic                 axi_b_ready_i;
    logic                 req_valid_o;
    hpdcache_mem_req_t    req_o;
    logic                 req_ready_i;
    logic                 req_data_valid_o;
    hpdcache_mem_req_w_t  req_data_o;
    logic                 req_data_ready_i;
    logic                 resp_valid_i;
    hpdcache_mem_resp_w_t resp_i;
    logic                 resp_ready_o;

    modport slave (
        input  axi_aw_valid_i, axi_aw_i, axi_w_valid_i, axi_w_i, axi_b_ready_i,
               req_ready_i, req_data_ready_i, resp_valid_i, resp_i,
        output axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_o,
               req_valid_o, req_o, req_data_valid_o, req_data_o, resp_ready_o
    );

    modport master (
        output axi_aw_valid_i, axi_aw_i, axi_w_valid_i, axi_w_i, axi_b_ready_i,
               req_ready_i, req_data_ready_i, resp_valid_i, resp_i,
        input  axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_o,
               req_valid_o, req_o, req_data_valid_o, req_data_o, resp_ready_o
    );
endinterface

// File: rtl/hpdcache_axi_to_mem_write.sv
// AXI4 write-channel responder: turns one AW/W transaction at a time into an
// hpdcache memory write request plus write data, and turns hpdcache memory
// write responses into AXI B responses through a one-entry B slot.
// Unsupported atomics (AtomicStore, AtomicCompare, reserved atop) are drained
// locally and answered with SLVERR.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : AXI AW/W/B and hpdcache req/req_data/resp_w channels
//   len_err_o     : one-cycle pulse when W.last disagrees with AW.len framing
// Optional feature: define HPDCACHE_AXI_TO_MEM_WRITE_LEN_CHECK_EN to build the
// W.last check (len_err_o + assertion); otherwise len_err_o is tied to 0.
module hpdcache_axi_to_mem_write
    import hpdcache_axi_to_mem_write_pkg::*;
#(
    parameter type hpdcache_mem_req_t    = hpdcache_axi_to_mem_write_pkg::hpdcache_mem_req_t,
    parameter type hpdcache_mem_req_w_t  = hpdcache_axi_to_mem_write_pkg::hpdcache_mem_req_w_t,
    parameter type hpdcache_mem_resp_w_t = hpdcache_axi_to_mem_write_pkg::hpdcache_mem_resp_w_t,
    parameter type aw_chan_t             = hpdcache_axi_to_mem_write_pkg::aw_chan_t,
    parameter type w_chan_t              = hpdcache_axi_to_mem_write_pkg::w_chan_t,
    parameter type b_chan_t              = hpdcache_axi_to_mem_write_pkg::b_chan_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    hpdcache_axi_to_mem_write_if.slave bus,
    output logic                       len_err_o
);
    typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, ERESP} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    hpdcache_mem_req_t req_q, req_d;
    logic              b_full_q, b_full_d;
    b_chan_t           b_q, b_d;

    logic aw_ready, w_ready, req_valid, req_data_valid;
    logic resp_ready, resp_load, eresp_load;

    // Only plain writes, AtomicLoad and AtomicSwap reach memory; AtomicCompare
    // is unsupported downstream and is rejected with the reserved encodings.
    function automatic logic atop_rejected(input logic [5:0] atop);
        case (atop[5:4])
            ATOP_NONE:        return atop[3:0] != 4'd0;
            ATOP_ATOMICSTORE: return 1'b1;
            ATOP_ATOMICLOAD:  return 1'b0;
            default:          return atop[3:0] != 4'd0;
        endcase
    endfunction

    function automatic hpdcache_mem_req_t decode_aw(input aw_chan_t aw);
        hpdcache_mem_req_t r;
        r = '0;
        r.mem_req_addr      = aw.addr;
        r.mem_req_len       = aw.len;
        r.mem_req_size      = aw.size;
        r.mem_req_id        = aw.id;
        r.mem_req_cacheable = aw.cache[1] & ~aw.lock;
        r.mem_req_command   = (aw.lock || aw.atop != 6'd0) ? HPDCACHE_MEM_ATOMIC
                                                           : HPDCACHE_MEM_WRITE;
        r.mem_req_atomic    = HPDCACHE_MEM_ATOMIC_ADD;
        if (aw.lock) begin
            r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_STEX;
        end else if (aw.atop[5:4] == ATOP_ATOMICLOAD) begin
            case (aw.atop[2:0])
                3'd0:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_ADD;
                3'd1:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_CLR;
                3'd2:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_EOR;
                3'd3:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_SET;
                3'd4:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_SMAX;
                3'd5:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_SMIN;
                3'd6:    r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_UMAX;
                default: r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_UMIN;
            endcase
        end else if (aw.atop[5:4] == ATOP_ATOMICSWCMP) begin
            r.mem_req_atomic = HPDCACHE_MEM_ATOMIC_SWAP;
        end
        return r;
    endfunction

    assign resp_ready = ~b_full_q | bus.axi_b_ready_i;
    assign resp_load  = bus.resp_valid_i & resp_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        aw_ready       = 1'b0;
        w_ready        = 1'b0;
        req_valid      = 1'b0;
        req_data_valid = 1'b0;
        eresp_load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                aw_ready = 1'b1;
                if (bus.axi_aw_valid_i) begin
                    req_d   = decode_aw(bus.axi_aw_i);
                    cnt_d   = bus.axi_aw_i.len;
                    state_d = atop_rejected(bus.axi_aw_i.atop) ? DRAIN : REQ;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (bus.req_ready_i) state_d = DATA;
            end
            DATA: begin
                w_ready        = bus.req_data_ready_i;
                req_data_valid = bus.axi_w_valid_i;
                if (bus.axi_w_valid_i && bus.req_data_ready_i) begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 8'd1;
                end
            end
            DRAIN: begin
                w_ready = 1'b1;
                if (bus.axi_w_valid_i) begin
                    if (cnt_q == '0) state_d = ERESP;
                    else             cnt_d   = cnt_q - 8'd1;
                end
            end
            ERESP: begin
                // A memory response loading the slot this cycle has priority.
                if (resp_ready && !resp_load) begin
                    eresp_load = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        b_full_d = b_full_q;
        b_d      = b_q;
        if (resp_load) begin
            b_full_d = 1'b1;
            b_d.id   = bus.resp_i.mem_resp_w_id;
            if (bus.resp_i.mem_resp_w_error == HPDCACHE_MEM_RESP_NOK) b_d.resp = AXI_RESP_SLVERR;
            else if (bus.resp_i.mem_resp_w_is_atomic)                b_d.resp = AXI_RESP_EXOKAY;
            else                                                     b_d.resp = AXI_RESP_OKAY;
        end else if (eresp_load) begin
            b_full_d = 1'b1;
            b_d.id   = req_q.mem_req_id;
            b_d.resp = AXI_RESP_SLVERR;
        end else if (b_full_q && bus.axi_b_ready_i) begin
            b_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            b_full_q <= 1'b0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            b_full_q <= b_full_d;
            b_q      <= b_d;
        end
    end

    assign bus.axi_aw_ready_o   = aw_ready;
    assign bus.axi_w_ready_o    = w_ready;
    assign bus.axi_b_valid_o    = b_full_q;
    assign bus.axi_b_o          = b_q;
    assign bus.req_valid_o      = req_valid;
    assign bus.req_o            = req_q;
    assign bus.req_data_valid_o = req_data_valid;
    assign bus.resp_ready_o     = resp_ready;

    // Write-data last is framed by the beat counter, never by W.last.
    always_comb begin
        bus.req_data_o                = '0;
        bus.req_data_o.mem_req_w_data = bus.axi_w_i.data;
        bus.req_data_o.mem_req_w_be   = bus.axi_w_i.strb;
        bus.req_data_o.mem_req_w_last = (cnt_q == '0);
    end

    logic unused_aw;
    assign unused_aw = ^{bus.axi_aw_i.burst, bus.axi_aw_i.cache[3:2], bus.axi_aw_i.cache[0],
                         bus.axi_aw_i.prot, bus.axi_aw_i.qos, bus.axi_aw_i.region};

`ifdef HPDCACHE_AXI_TO_MEM_WRITE_LEN_CHECK_EN
    logic len_err;
    assign len_err = (state_q == DATA || state_q == DRAIN) && bus.axi_w_valid_i && w_ready
                     && (bus.axi_w_i.last != (cnt_q == '0));
    assign len_err_o = len_err;

    len_framing_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !len_err)
        else $warning("W.last disagrees with AW.len beat count");
`else
    assign len_err_o = 1'b0;
    logic unused_w_last;
    assign unused_w_last = bus.axi_w_i.last;
`endif
endmodule

// File: tb/tb_hpdcache_axi_to_mem_write.sv
`timescale 1ns/1ps
module tb_hpdcache_axi_to_mem_write;
    import hpdcache_axi_to_mem_write_pkg::*;

    localparam int unsigned TMO = 200;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } exp_b_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic len_err;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_b_t exp_q[$];

    hpdcache_mem_atomic_e ld_ops [8] = '{
        HPDCACHE_MEM_ATOMIC_ADD,  HPDCACHE_MEM_ATOMIC_CLR,  HPDCACHE_MEM_ATOMIC_EOR,
        HPDCACHE_MEM_ATOMIC_SET,  HPDCACHE_MEM_ATOMIC_SMAX, HPDCACHE_MEM_ATOMIC_SMIN,
        HPDCACHE_MEM_ATOMIC_UMAX, HPDCACHE_MEM_ATOMIC_UMIN};

    hpdcache_axi_to_mem_write_if bus ();

    hpdcache_axi_to_mem_write dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .len_err_o (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Served at memory: plain writes, AtomicLoad (any op) and AtomicSwap.
    function automatic bit served(input aw_chan_t aw);
        if (aw.atop == 6'b000000)     return 1'b1;
        if (aw.atop[5:4] == 2'b10)    return 1'b1;
        if (aw.atop == 6'b110000)     return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_len_err(input logic drv_last, input logic final_beat);
`ifdef HPDCACHE_AXI_TO_MEM_WRITE_LEN_CHECK_EN
        return drv_last != final_beat;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] b_code(input logic err, input logic atom);
        if (err)  return AXI_RESP_SLVERR;
        if (atom) return AXI_RESP_EXOKAY;
        return AXI_RESP_OKAY;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect_all();
        int unsigned k = 0;
        exp_b_t e;
        while (exp_q.size() > 0 && k < TMO) begin
            bus.axi_b_ready_i = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (bus.axi_b_valid_o && bus.axi_b_ready_i) begin
                e = exp_q.pop_front();
                check("b_id", bus.axi_b_o.id, e.id);
                check("b_resp", bus.axi_b_o.resp, e.resp);
            end
            tick();
            k++;
        end
        check("b_pending", exp_q.size(), 0);
        bus.axi_b_ready_i = 1'b0;
        @(negedge clk);
        check("b_slot_empty", bus.axi_b_valid_o, 1'b0);
        tick();
    endtask

    task automatic run_txn(input aw_chan_t aw, input int bad_beat, input logic r_err,
                           input logic r_atom, input bit do_resp, input bit do_collect);
        int unsigned n;
        int unsigned k;
        int unsigned d;
        bit sup;
        bit hs;
        logic wl;
        logic [DATA_W-1:0] wd;
        logic [BE_W-1:0] wb;
        exp_b_t eb;
        n   = 32'(aw.len) + 1;
        sup = served(aw);

        bus.axi_aw_i = aw;
        bus.axi_aw_valid_i = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.axi_aw_ready_o && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check("aw_accept", k < TMO, 1'b1);
        tick();
        bus.axi_aw_valid_i = 1'b0;
        bus.axi_w_valid_i = 1'b1;

        if (sup) begin
            d = $urandom_range(0, 2);
            for (int unsigned i = 0; i <= d; i++) begin
                bus.req_ready_i = (i == d);
                @(negedge clk);
                check("req_valid", bus.req_valid_o, 1'b1);
                check("w_blocked_in_req", bus.axi_w_ready_o, 1'b0);
                if (i == 0) begin
                    check("req_cmd", bus.req_o.mem_req_command,
                          (aw.lock || aw.atop != 0) ? HPDCACHE_MEM_ATOMIC : HPDCACHE_MEM_WRITE);
                    if (aw.lock)
                        check("req_atomic", bus.req_o.mem_req_atomic, HPDCACHE_MEM_ATOMIC_STEX);
                    else if (aw.atop[5:4] == 2'b10)
                        check("req_atomic", bus.req_o.mem_req_atomic, ld_ops[aw.atop[2:0]]);
                    else if (aw.atop != 0)
                        check("req_atomic", bus.req_o.mem_req_atomic, HPDCACHE_MEM_ATOMIC_SWAP);
                    check("req_cacheable", bus.req_o.mem_req_cacheable, aw.cache[1] && !aw.lock);
                    check("req_id", bus.req_o.mem_req_id, aw.id);
                    check("req_addr", bus.req_o.mem_req_addr, aw.addr);
                    check("req_len", bus.req_o.mem_req_len, aw.len);
                    check("req_size", bus.req_o.mem_req_size, aw.size);
                end
                tick();
            end
            bus.req_ready_i = 1'b0;
        end

        for (int unsigned b = 0; b < n; b++) begin
            wd = {$urandom, $urandom};
            wb = BE_W'($urandom);
            wl = (b == n - 1) || (int'(b) == bad_beat);
            bus.axi_w_i.data = wd;
            bus.axi_w_i.strb = wb;
            bus.axi_w_i.last = wl;
            bus.axi_w_valid_i = 1'b1;
            hs = 1'b0;
            k = 0;
            while (!hs && k < TMO) begin
                if (sup) bus.req_data_ready_i = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                hs = sup ? bus.req_data_ready_i : 1'b1;
                if (sup) begin
                    check("w_ready_data", bus.axi_w_ready_o, bus.req_data_ready_i);
                    check("req_data_valid", bus.req_data_valid_o, 1'b1);
                end else begin
                    check("w_ready_drain", bus.axi_w_ready_o, 1'b1);
                    check("drain_quiet", {bus.req_valid_o, bus.req_data_valid_o}, 2'b00);
                end
                if (hs && sup) begin
                    check("wdata", bus.req_data_o.mem_req_w_data, wd);
                    check("wbe", bus.req_data_o.mem_req_w_be, wb);
                    check("wlast", bus.req_data_o.mem_req_w_last, b == n - 1);
                end
                check("len_err", len_err, hs ? exp_len_err(wl, b == n - 1) : 1'b0);
                tick();
                k++;
            end
            check("w_beat_accept", hs, 1'b1);
            bus.axi_w_valid_i = 1'b0;
            bus.req_data_ready_i = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("len_err_gap", len_err, 1'b0);
                tick();
            end
        end

        if (!sup) begin
            eb.id = aw.id;
            eb.resp = AXI_RESP_SLVERR;
            exp_q.push_back(eb);
        end else if (do_resp) begin
            bus.resp_i.mem_resp_w_error = r_err ? HPDCACHE_MEM_RESP_NOK : HPDCACHE_MEM_RESP_OK;
            bus.resp_i.mem_resp_w_id = aw.id;
            bus.resp_i.mem_resp_w_is_atomic = r_atom;
            bus.resp_valid_i = 1'b1;
            k = 0;
            @(negedge clk);
            while (!bus.resp_ready_o && k < TMO) begin
                @(negedge clk);
                k++;
            end
            check("resp_accept", k < TMO, 1'b1);
            eb.id = aw.id;
            eb.resp = b_code(r_err, r_atom);
            exp_q.push_back(eb);
            tick();
            bus.resp_valid_i = 1'b0;
        end
        if (do_collect) collect_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        aw_chan_t aw;
        aw_chan_t aw2;
        exp_b_t eb;
        exp_b_t e;
        int bad;
        bus.axi_aw_valid_i = 1'b0;
        bus.axi_aw_i = '0;
        bus.axi_w_valid_i = 1'b0;
        bus.axi_w_i = '0;
        bus.axi_b_ready_i = 1'b0;
        bus.req_ready_i = 1'b0;
        bus.req_data_ready_i = 1'b0;
        bus.resp_valid_i = 1'b0;
        bus.resp_i = '0;

        #3;
        check("rst_aw_ready", bus.axi_aw_ready_o, 1'b1);
        check("rst_w_ready", bus.axi_w_ready_o, 1'b0);
        check("rst_b_valid", bus.axi_b_valid_o, 1'b0);
        check("rst_req_valid", bus.req_valid_o, 1'b0);
        check("rst_req_data_valid", bus.req_data_valid_o, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_resp_ready", bus.resp_ready_o, 1'b1);
        #13 rst_n = 1'b1;
        tick();

        // Plain cacheable burst of 4 beats.
        aw = '0; aw.id = 4'd3; aw.addr = 32'h1000; aw.len = 8'd3; aw.size = 3'd3; aw.cache = 4'hF; aw.burst = 2'b01;
        run_txn(aw, -1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Exclusive store: EXOKAY then OKAY.
        aw = '0; aw.id = 4'd5; aw.lock = 1'b1; aw.cache = 4'hF; aw.addr = 32'h2000;
        run_txn(aw, -1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_txn(aw, -1, 1'b0, 1'b0, 1'b1, 1'b1);

        // AtomicLoad UMAX with NOK response.
        aw = '0; aw.id = 4'd2; aw.atop = 6'b100110; aw.addr = 32'h3000; aw.size = 3'd3;
        run_txn(aw, -1, 1'b1, 1'b1, 1'b1, 1'b1);

        // AtomicStore ADD: drained locally.
        aw = '0; aw.id = 4'd7; aw.atop = 6'b010000; aw.len = 8'd1;
        run_txn(aw, -1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Early W.last on beat 0 of a 2-beat burst.
        aw = '0; aw.id = 4'd1; aw.len = 8'd1; aw.addr = 32'h4000;
        run_txn(aw, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // B back-pressure with a second memory response pending.
        aw = '0; aw.id = 4'd8; aw.addr = 32'h5000;
        run_txn(aw, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        aw2 = '0; aw2.id = 4'd9; aw2.addr = 32'h5040;
        run_txn(aw2, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.resp_i.mem_resp_w_error = HPDCACHE_MEM_RESP_OK;
        bus.resp_i.mem_resp_w_id = aw2.id;
        bus.resp_i.mem_resp_w_is_atomic = 1'b1;
        bus.resp_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_resp_ready", bus.resp_ready_o, 1'b0);
            check("bp_b_valid", bus.axi_b_valid_o, 1'b1);
            check("bp_b_id", bus.axi_b_o.id, aw.id);
            tick();
        end
        bus.axi_b_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus.resp_ready_o, 1'b1);
        check("bp_b_valid_rel", bus.axi_b_valid_o, 1'b1);
        e = exp_q.pop_front();
        check("bp_b_id_first", bus.axi_b_o.id, e.id);
        check("bp_b_resp_first", bus.axi_b_o.resp, e.resp);
        eb.id = aw2.id;
        eb.resp = AXI_RESP_EXOKAY;
        exp_q.push_back(eb);
        tick();
        bus.resp_valid_i = 1'b0;
        collect_all();

        // Reset in the middle of a transaction with a full B slot.
        aw = '0; aw.id = 4'd10; aw.addr = 32'h6000;
        run_txn(aw, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        aw.id = 4'd11;
        bus.axi_aw_i = aw;
        bus.axi_aw_valid_i = 1'b1;
        @(negedge clk);
        check("mid_aw_ready", bus.axi_aw_ready_o, 1'b1);
        tick();
        bus.axi_aw_valid_i = 1'b0;
        @(negedge clk);
        check("mid_req_valid", bus.req_valid_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", bus.req_valid_o, 1'b0);
        check("mid_rst_aw_ready", bus.axi_aw_ready_o, 1'b1);
        check("mid_rst_b_valid", bus.axi_b_valid_o, 1'b0);
        check("mid_rst_resp_ready", bus.resp_ready_o, 1'b1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            aw = '0;
            aw.id = 4'($urandom);
            aw.addr = $urandom;
            aw.len = 8'($urandom_range(0, 5));
            aw.size = 3'($urandom_range(0, 3));
            aw.cache = 4'($urandom);
            aw.burst = 2'b01;
            case ($urandom_range(0, 7))
                0: aw.lock = 1'b1;
                1: aw.atop = {2'b10, 1'($urandom), 3'($urandom)};
                2: aw.atop = 6'b110000;
                3: aw.atop = {2'b01, 4'($urandom)};
                4: aw.atop = {2'b11, 4'($urandom_range(2, 15))};
                default: aw.atop = 6'b000000;
            endcase
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32'(aw.len))) : -1;
            run_txn(aw, bad, ($urandom_range(0, 3) == 0), 1'($urandom), 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
